// File: rtl/tt_ctrl_seq_if.sv
// Request/response and mux-control bundle for the tt_ctrl_seq select sequencer.
// The master side issues "select design N" requests and observes the
// resulting control lines; the slave side is the sequencer itself.
interface tt_ctrl_seq_if #(
    parameter int ADDR_W = 10,
    parameter int PW_W   = 8
);

    // request handshake
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ena;
    logic [PW_W-1:0]   pulse_len;

    // status
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] cur_addr;

    // serial select lines toward the mux controller
    logic              ctrl_sel_rst_n;
    logic              ctrl_sel_inc;
    logic              ctrl_ena;

    modport master (
        output req_valid,
        output req_addr,
        output req_ena,
        output pulse_len,
        input  req_ready,
        input  busy,
        input  done,
        input  cur_addr,
        input  ctrl_sel_rst_n,
        input  ctrl_sel_inc,
        input  ctrl_ena
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_ena,
        input  pulse_len,
        output req_ready,
        output busy,
        output done,
        output cur_addr,
        output ctrl_sel_rst_n,
        output ctrl_sel_inc,
        output ctrl_ena
    );

endinterface

// File: rtl/tt_ctrl_seq.sv
// tt_ctrl_seq: turns a parallel "select design N" request into the serial
// pulse train the mux controller expects: disable, pulse the select-counter
// reset, emit N increment pulses, then drive the requested final enable.
// Every phase lasts L = max(pulse_len,1) cycles, and all outputs come straight
// from flops so the control lines cannot glitch.
module tt_ctrl_seq #(
    parameter int ADDR_W = 10,
    parameter int PW_W   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    tt_ctrl_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIS,
        ST_RST_LO,
        ST_RST_HI,
        ST_INC_HI,
        ST_INC_LO,
        ST_DONE
    } state_t;

    localparam logic [PW_W-1:0]   PW_ONE   = {{(PW_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;

    // captured request
    logic [PW_W-1:0]   len_m1;
    logic [ADDR_W-1:0] addr_q;
    logic              fin_ena;

    // phase timing and remaining increment pulses
    logic [PW_W-1:0]   phase_cnt;
    logic [ADDR_W-1:0] inc_cnt;

    // registered outputs
    logic              ready_r;
    logic              busy_r;
    logic              done_r;
    logic [ADDR_W-1:0] cur_addr_r;
    logic              sel_rst_n_r;
    logic              sel_inc_r;
    logic              ena_r;

    // decoded helpers
    logic [PW_W-1:0]   req_len_m1;
    logic              phase_last;

    // L-1 for the incoming request, with a zero length treated as one cycle
    always_comb begin
        req_len_m1 = '0;
        if (bus.pulse_len != '0) begin
            req_len_m1 = bus.pulse_len - PW_ONE;
        end
        phase_last = (phase_cnt == '0);
    end

    // sequencer state, phase timing and every registered output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            len_m1      <= '0;
            addr_q      <= '0;
            fin_ena     <= 1'b0;
            phase_cnt   <= '0;
            inc_cnt     <= '0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cur_addr_r  <= '0;
            sel_rst_n_r <= 1'b0;
            sel_inc_r   <= 1'b0;
            ena_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && ready_r) begin
                        len_m1    <= req_len_m1;
                        addr_q    <= bus.req_addr;
                        fin_ena   <= bus.req_ena;
                        inc_cnt   <= bus.req_addr;
                        phase_cnt <= req_len_m1;
                        ena_r     <= 1'b0;
                        busy_r    <= 1'b1;
                        ready_r   <= 1'b0;
                        state     <= ST_DIS;
                    end
                end

                ST_DIS: begin
                    if (phase_last) begin
                        sel_rst_n_r <= 1'b0;
                        phase_cnt   <= len_m1;
                        state       <= ST_RST_LO;
                    end else begin
                        phase_cnt <= phase_cnt - PW_ONE;
                    end
                end

                ST_RST_LO: begin
                    if (phase_last) begin
                        sel_rst_n_r <= 1'b1;
                        phase_cnt   <= len_m1;
                        state       <= ST_RST_HI;
                    end else begin
                        phase_cnt <= phase_cnt - PW_ONE;
                    end
                end

                ST_RST_HI: begin
                    if (phase_last) begin
                        if (inc_cnt != '0) begin
                            sel_inc_r <= 1'b1;
                            phase_cnt <= len_m1;
                            state     <= ST_INC_HI;
                        end else begin
                            ena_r      <= fin_ena;
                            done_r     <= 1'b1;
                            cur_addr_r <= addr_q;
                            busy_r     <= 1'b0;
                            state      <= ST_DONE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - PW_ONE;
                    end
                end

                ST_INC_HI: begin
                    if (phase_last) begin
                        sel_inc_r <= 1'b0;
                        phase_cnt <= len_m1;
                        state     <= ST_INC_LO;
                    end else begin
                        phase_cnt <= phase_cnt - PW_ONE;
                    end
                end

                ST_INC_LO: begin
                    if (phase_last) begin
                        inc_cnt <= inc_cnt - ADDR_ONE;
                        if (inc_cnt == ADDR_ONE) begin
                            ena_r      <= fin_ena;
                            done_r     <= 1'b1;
                            cur_addr_r <= addr_q;
                            busy_r     <= 1'b0;
                            state      <= ST_DONE;
                        end else begin
                            sel_inc_r <= 1'b1;
                            phase_cnt <= len_m1;
                            state     <= ST_INC_HI;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - PW_ONE;
                    end
                end

                ST_DONE: begin
                    ready_r <= 1'b1;
                    state   <= ST_IDLE;
                end

                default: begin
                    sel_inc_r <= 1'b0;
                    busy_r    <= 1'b0;
                    ready_r   <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = ready_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.cur_addr       = cur_addr_r;
    assign bus.ctrl_sel_rst_n = sel_rst_n_r;
    assign bus.ctrl_sel_inc   = sel_inc_r;
    assign bus.ctrl_ena       = ena_r;

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// Testbench for tt_ctrl_seq: a cycle-level reference model derived from the
// phase arithmetic (cycle k of a sequence falls in phase (k-1)/L) is compared
// against every DUT output on every cycle, alongside table-driven request
// vectors, directed corner sequences and randomized traffic.
module tb_tt_ctrl_seq;

    localparam int ADDR_W = 10;
    localparam int PW_W   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tt_ctrl_seq_if #(.ADDR_W(ADDR_W), .PW_W(PW_W)) bus ();

    tt_ctrl_seq #(.ADDR_W(ADDR_W), .PW_W(PW_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int addr;
        int plen;
        int ena;
        int exp_lat;
        int exp_incs;
        int exp_rlo_first;
        int exp_rlo_len;
        int exp_first_inc;
    } vec_t;

    vec_t vecs [8];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model state
    int m_rst_n, m_inc, m_ena, m_ready, m_busy, m_done, m_cur;
    int m_active, m_k, m_L, m_A, m_E, m_accepted;

    task automatic checkOne(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // advance the model by one rising edge using the inputs present at that edge
    task automatic modelEdge();
        int total;
        int p;
        m_accepted = 0;
        if (rst_n == 1'b0) begin
            m_rst_n = 0; m_inc = 0; m_ena = 0; m_ready = 1;
            m_busy = 0; m_done = 0; m_cur = 0; m_active = 0;
        end else if (m_active != 0) begin
            m_k++;
            total  = m_L * (3 + 2 * m_A);
            m_done = 0;
            if (m_k == total + 1) begin
                m_done = 1; m_ena = m_E; m_cur = m_A; m_busy = 0; m_inc = 0;
            end else if (m_k == total + 2) begin
                m_active = 0; m_ready = 1;
            end else begin
                p      = (m_k - 1) / m_L;
                m_busy = 1;
                if (p == 0) m_ena = 0;
                else if (p == 1) m_rst_n = 0;
                else if (p == 2) m_rst_n = 1;
                m_inc = ((p >= 3) && (((p - 3) % 2) == 0)) ? 1 : 0;
            end
        end else begin
            m_done = 0;
            if (bus.req_valid == 1'b1) begin
                m_active = 1; m_k = 1;
                m_A = int'(bus.req_addr);
                m_E = int'(bus.req_ena);
                m_L = (bus.pulse_len == '0) ? 1 : int'(bus.pulse_len);
                m_ena = 0; m_busy = 1; m_ready = 0; m_accepted = 1;
            end
        end
    endtask

    task automatic checkOutput();
        checkOne("ctrl_sel_rst_n", int'(bus.ctrl_sel_rst_n), m_rst_n);
        checkOne("ctrl_sel_inc",   int'(bus.ctrl_sel_inc),   m_inc);
        checkOne("ctrl_ena",       int'(bus.ctrl_ena),       m_ena);
        checkOne("req_ready",      int'(bus.req_ready),      m_ready);
        checkOne("busy",           int'(bus.busy),           m_busy);
        checkOne("done",           int'(bus.done),           m_done);
        checkOne("cur_addr",       int'(bus.cur_addr),       m_cur);
    endtask

    // one clock: model on the rising edge, compare on the falling edge
    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        cyc++;
        checkOutput();
    endtask

    // issue one request and measure its pulse train against the table entry
    task automatic applyStimulus(input vec_t tv);
        int n, L, incs, rlo_first, rlo_len, first_inc, prev_inc, limit;
        L = (tv.plen == 0) ? 1 : tv.plen;
        limit = tv.exp_lat + 20;
        incs = 0; rlo_first = 0; rlo_len = 0; first_inc = 0; prev_inc = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = ADDR_W'(tv.addr);
        bus.pulse_len = PW_W'(tv.plen);
        bus.req_ena   = tv.ena[0];
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = ADDR_W'($urandom);
        bus.pulse_len = PW_W'($urandom);
        bus.req_ena   = 1'($urandom);
        n = 1;
        checkOne("dis_ena_low", int'(bus.ctrl_ena), 0);
        forever begin
            if (n > L && bus.ctrl_sel_rst_n == 1'b0) begin
                if (rlo_first == 0) rlo_first = n;
                rlo_len++;
            end
            if (bus.ctrl_sel_inc == 1'b1 && prev_inc == 0) begin
                incs++;
                if (first_inc == 0) first_inc = n;
            end
            prev_inc = int'(bus.ctrl_sel_inc);
            if (bus.done == 1'b1 || n >= limit) break;
            tick();
            n++;
        end
        checkOne("done_seen",    int'(bus.done), 1);
        checkOne("latency",      n, tv.exp_lat);
        checkOne("inc_pulses",   incs, tv.exp_incs);
        checkOne("rst_lo_first", rlo_first, tv.exp_rlo_first);
        checkOne("rst_lo_len",   rlo_len, tv.exp_rlo_len);
        checkOne("first_inc",    first_inc, tv.exp_first_inc);
        checkOne("final_ena",    int'(bus.ctrl_ena), tv.ena);
        checkOne("final_addr",   int'(bus.cur_addr), tv.addr);
        tick();
    endtask

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, first_done, second_start, guard;

        //            addr  plen ena  lat  incs rlo_first rlo_len first_inc
        vecs[0] = '{   3,    2,   1,   19,   3,    3,       2,       7 };
        vecs[1] = '{   0,    0,   0,    4,   0,    2,       1,       0 };
        vecs[2] = '{   1,    1,   1,    6,   1,    2,       1,       4 };
        vecs[3] = '{   2,    3,   0,   22,   2,    4,       3,      10 };
        vecs[4] = '{   0,    4,   1,   13,   0,    5,       4,       0 };
        vecs[5] = '{   5,    1,   0,   14,   5,    2,       1,       4 };
        vecs[6] = '{1023,    1,   1, 2050, 1023,   2,       1,       4 };
        vecs[7] = '{   1,  255,   1, 1276,   1,  256,     255,     766 };

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_ena   = 1'b0;
        bus.pulse_len = '0;
        rst_n = 1'b0;

        // reset held three cycles, then released
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checkOne("reset_rst_n",    int'(bus.ctrl_sel_rst_n), 0);
        checkOne("reset_inc",      int'(bus.ctrl_sel_inc), 0);
        checkOne("reset_ena",      int'(bus.ctrl_ena), 0);
        checkOne("reset_ready",    int'(bus.req_ready), 1);
        checkOne("reset_cur_addr", int'(bus.cur_addr), 0);
        checkOne("reset_done",     int'(bus.done), 0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // request held while busy with a different address is only taken after DONE
        bus.req_valid = 1'b1; bus.req_addr = 10'd2; bus.pulse_len = 8'd1; bus.req_ena = 1'b1;
        tick();
        bus.req_addr = 10'd4; bus.pulse_len = 8'd2; bus.req_ena = 1'b0;
        n = 1; first_done = 0; second_start = 0;
        while (second_start == 0 && n < 100) begin
            tick();
            n++;
            if (bus.done == 1'b1 && first_done == 0) begin
                first_done = n;
                checkOne("ign_cur_addr1", int'(bus.cur_addr), 2);
                checkOne("ign_ena1", int'(bus.ctrl_ena), 1);
            end
            if (m_accepted != 0) second_start = n;
        end
        bus.req_valid = 1'b0;
        checkOne("ign_first_done", first_done, 8);
        checkOne("ign_second_accept", second_start, 10);
        checkOne("ign_second_ena_low", int'(bus.ctrl_ena), 0);
        n = 1;
        while (bus.done != 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checkOne("ign_second_latency", n, 23);
        checkOne("ign_cur_addr2", int'(bus.cur_addr), 4);
        checkOne("ign_ena2", int'(bus.ctrl_ena), 0);
        tick();

        // reset asserted while an increment pulse is high
        bus.req_valid = 1'b1; bus.req_addr = 10'd2; bus.pulse_len = 8'd3; bus.req_ena = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        guard = 0;
        while (bus.ctrl_sel_inc != 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        checkOne("mid_inc_reached", int'(bus.ctrl_sel_inc), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOne("mid_rst_inc",   int'(bus.ctrl_sel_inc), 0);
        checkOne("mid_rst_rst_n", int'(bus.ctrl_sel_rst_n), 0);
        checkOne("mid_rst_ena",   int'(bus.ctrl_ena), 0);
        checkOne("mid_rst_ready", int'(bus.req_ready), 1);
        repeat (20) tick();
        applyStimulus(vecs[0]);

        // randomized traffic, occasional resets, inputs changing mid-sequence
        for (int r = 0; r < 1500; r++) begin
            bus.req_valid = ($urandom_range(0, 3) == 0);
            bus.req_addr  = ADDR_W'($urandom_range(0, 15));
            bus.pulse_len = PW_W'($urandom_range(0, 3));
            bus.req_ena   = 1'($urandom);
            rst_n         = ($urandom_range(0, 399) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
